instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 0, meaning the word index fetched first after reset.
REQ-002 The block SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, meaning the instruction word that stops fetching.
REQ-003 The block SHALL have parameter MEM_SIZE, default 1000, meaning the highest legal word index of instruction memory.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port pc, output, 32 bits: word index presented to instruction memory.
REQ-007 The block SHALL have port ins, input, 32 bits: instruction word from memory, combinationally valid for the current pc in the same cycle.
REQ-008 The block SHALL have port redirect_valid, input, 1 bit: one-cycle request to restart fetch.
REQ-009 The block SHALL have port redirect_pc, input, 32 bits: word index for the restart.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the buffer head holds an instruction.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the decode stage accepts the head this cycle.
REQ-012 The block SHALL have port out_ins, output, 32 bits: instruction at the buffer head.
REQ-013 The block SHALL have port out_pc, output, 32 bits: word index of out_ins.
REQ-014 The block SHALL have port halted, output, 1 bit: the FSM is in HALT.
REQ-015 The block SHALL have port fault, output, 1 bit: the FSM is in FAULT.

Function
REQ-016 The block SHALL contain a 2-entry FIFO of {pc, ins} pairs.
- out_valid SHALL be high exactly when the FIFO count is greater than 0.
- out_ins and out_pc SHALL be driven from the FIFO head.
REQ-017 A pop SHALL occur exactly when out_valid and out_ready are both high.
REQ-018 The FSM SHALL have states RUN, HALT and FAULT; halted = (state==HALT) and fault = (state==FAULT).
REQ-019 In RUN, a fetch SHALL be attempted when the count is below 2, or when the count is 2 and a pop occurs in the same cycle.
REQ-020 When a fetch is attempted and pc > MEM_SIZE:
- the block SHALL enter FAULT;
- nothing SHALL be enqueued;
- pc SHALL hold.
REQ-021 When a fetch is attempted, pc <= MEM_SIZE and ins == HALT_WORD:
- the block SHALL enter HALT;
- nothing SHALL be enqueued;
- pc SHALL hold;
- entries already buffered SHALL still drain normally.
REQ-022 Otherwise, an attempted fetch SHALL enqueue {pc, ins} and set pc <= pc + 1 with 32-bit wrap-around.
REQ-023 A simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-024 In RUN with no attempted fetch, pc SHALL hold.
REQ-025 In HALT and FAULT, no fetch SHALL occur and pc SHALL hold; pops SHALL continue.
REQ-026 redirect_valid SHALL have highest priority in any state and SHALL, at the next edge:
- flush the FIFO to count 0, discarding any same-cycle push or pop;
- set pc <= redirect_pc;
- set state <= RUN.
REQ-027 Latency SHALL be as follows:
- an instruction fetched at edge N is visible on out_ins with out_valid=1 after edge N when the FIFO was empty;
- the first fetch after reset or redirect SHALL occur at the first edge after rst_n deasserts or after the redirect edge.

Reset
REQ-028 While rst_n=0, the block SHALL hold the following, independent of clk:
- pc=RESET_PC;
- FIFO count=0, out_valid=0, out_ins=0, out_pc=0;
- state=RUN, halted=0, fault=0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries and any pending redirect.

Verification
REQ-030 The bench SHALL cover the straight-line program: memory words 0..5 = 0, 0x8D880000, 0x8D890001, 0x01095020, 0xAD8A0002, 0xFFFFFFFF, with out_ready=1.
- Required response: out_pc 0..4 delivered in order with matching out_ins.
- Required response: halted=1 after word 5 is seen, and pc holds at 5.
REQ-031 The bench SHALL cover backpressure: same program, out_ready=0 for 6 cycles, then 1.
- Required response: count saturates at 2 (words 0,1) and pc holds at 2.
- Required response: no word is lost or duplicated after release.
REQ-032 The bench SHALL cover redirect during HALT: after REQ-030 halts, pulse redirect_valid with redirect_pc=2.
- Required response: halted=0 at the next edge.
- Required response: out_pc 2,3,4 are delivered, then HALT again.
REQ-033 The bench SHALL cover the fault case: redirect_pc=1001.
- Required response: fault=1 one edge after the redirect edge, out_valid=0, and pc holds at 1001.
REQ-034 The bench SHALL cover redirect with a full FIFO and a simultaneous pop: redirect_pc=3.
- Required response: count=0 next cycle, and the next delivered out_pc is 3.
REQ-035 The bench SHALL cover asynchronous reset mid-stream with rst_n pulsed low between edges.
- Required response: out_valid=0 and pc=0 immediately.
- Required response: fetch restarts at word 0 after release.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Instruction fetch unit. Walks pc through instruction memory,
//            buffers {pc, ins} pairs in a 2-entry FIFO toward decode, stops on
//            a halt word or an out-of-range pc, and restarts on redirect.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int unsigned RESET_PC  = 0,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF,
    parameter int unsigned MEM_SIZE  = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    input  logic [31:0] ins,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        fault
);

    localparam logic [31:0] c_RESET_PC = 32'(RESET_PC);
    localparam logic [31:0] c_MEM_SIZE = 32'(MEM_SIZE);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_fifo_pc  [2];
    logic [31:0] r_fifo_ins [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic        w_pop;
    logic        w_attempt;
    logic        w_oob;
    logic        w_is_halt;
    logic        w_push;

    // A full FIFO can still take a fetch when its head leaves in the same cycle.
    assign w_pop     = (r_count != 2'd0) && out_ready;
    assign w_attempt = (r_state == S_RUN) && ((r_count != 2'd2) || w_pop);
    assign w_oob     = (r_pc > c_MEM_SIZE);
    assign w_is_halt = (ins == HALT_WORD);
    assign w_push    = w_attempt && !w_oob && !w_is_halt;

    assign pc        = r_pc;
    assign out_valid = (r_count != 2'd0);
    assign out_ins   = r_fifo_ins[r_rd_ptr];
    assign out_pc    = r_fifo_pc[r_rd_ptr];
    assign halted    = (r_state == S_HALT);
    assign fault     = (r_state == S_FAULT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: redirect wins; otherwise a fetch attempt may stop the unit.
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = S_RUN;
        end else if (w_attempt && w_oob) begin
            w_state_nxt = S_FAULT;
        end else if (w_attempt && w_is_halt) begin
            w_state_nxt = S_HALT;
        end
    end

    // Program counter: advances only when a word is actually enqueued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= c_RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_push) begin
            r_pc <= r_pc + 32'd1;
        end
    end

    // FIFO pointers, occupancy and storage; redirect discards everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_count       <= 2'd0;
            r_fifo_pc[0]  <= 32'd0;
            r_fifo_pc[1]  <= 32'd0;
            r_fifo_ins[0] <= 32'd0;
            r_fifo_ins[1] <= 32'd0;
        end else if (redirect_valid) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]  <= r_pc;
                r_fifo_ins[r_wr_ptr] <= ins;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Scoreboard bench for instr_fetch. Each (re)start pushes the whole
//            expected delivery sequence into a queue; a monitor pops it on
//            every accepted output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] c_HALT = 32'hFFFFFFFF;
    localparam int          c_MAX  = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic        halted;
    logic        fault;

    logic [31:0] mem [0:1023];
    logic [63:0] exp_q [$];
    logic [63:0] mon_e;
    int          checks = 0;
    int          failures = 0;

    instr_fetch #(
        .RESET_PC  (0),
        .HALT_WORD (c_HALT),
        .MEM_SIZE  (c_MAX)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .ins            (ins),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ins        (out_ins),
        .out_pc         (out_pc),
        .halted         (halted),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory.
    assign ins = (pc < 32'd1024) ? mem[pc[9:0]] : 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected delivery from a start index: consecutive words until a halt
    // word or an index beyond the memory limit.
    task automatic load_expect(input logic [31:0] start);
        logic [31:0] p;
        exp_q.delete();
        p = start;
        while (p <= 32'(c_MAX) && mem[p[9:0]] != c_HALT) begin
            exp_q.push_back({p, mem[p[9:0]]});
            p = p + 32'd1;
        end
    endtask

    // Monitor: every accepted head must match the scoreboard front.
    always @(negedge clk) begin
        if (rst_n && !redirect_valid && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: actual out_pc=%0h required=none", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_pc", out_pc, mon_e[63:32]);
                check("out_ins", out_ins, mon_e[31:0]);
            end
        end
    end

    // One-cycle redirect pulse; returns just after the redirect edge.
    task automatic do_redirect(input logic [31:0] tgt, input logic rdy);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        out_ready      = rdy;
        load_expect(tgt);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    // Wait until fetching has stopped and the buffer is empty.
    task automatic wait_idle(input int maxc, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!((halted || fault) && !out_valid) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= maxc) begin
            failures++;
            $display("FAIL %s_timeout: actual=busy required=idle", name);
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tgt;
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[1] = 32'h8D880000;
        mem[2] = 32'h8D890001;
        mem[3] = 32'h01095020;
        mem[4] = 32'hAD8A0002;
        mem[5] = c_HALT;

        // Reset values while rst_n is low.
        #12;
        check("rst_pc", pc, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_ins", out_ins, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        load_expect(32'd0);
        #5 rst_n = 1'b1;

        // Straight-line program.
        wait_idle(40, "straight");
        check("straight_halted", 32'(halted), 32'd1);
        check("straight_pc", pc, 32'd5);

        // Backpressure: two words buffered, pc stalls at 2.
        do_redirect(32'd0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("bp_pc", pc, 32'd2);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head_pc", out_pc, 32'd0);
        out_ready = 1'b1;
        wait_idle(40, "bp");
        check("bp_pc_end", pc, 32'd5);

        // Redirect out of HALT.
        do_redirect(32'd2, 1'b1);
        check("rd_halted_clear", 32'(halted), 32'd0);
        wait_idle(40, "rdhalt");
        check("rdhalt_halted", 32'(halted), 32'd1);
        check("rdhalt_pc", pc, 32'd5);

        // Fault on out-of-range restart.
        do_redirect(32'd1001, 1'b1);
        check("flt_not_yet", 32'(fault), 32'd0);
        @(posedge clk); #1;
        check("flt_fault", 32'(fault), 32'd1);
        check("flt_out_valid", 32'(out_valid), 32'd0);
        check("flt_pc", pc, 32'd1001);
        @(posedge clk); #1;
        check("flt_pc_hold", pc, 32'd1001);

        // Redirect with a full FIFO and a same-cycle pop.
        do_redirect(32'd0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("full_pc", pc, 32'd2);
        do_redirect(32'd3, 1'b1);
        check("full_flush", 32'(out_valid), 32'd0);
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("full_next_pc", out_pc, 32'd3);
        wait_idle(40, "full");

        // Asynchronous reset pulse between edges, mid-stream.
        do_redirect(32'd0, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        load_expect(32'd0);
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_pc", pc, 32'd0);
        check("arst_halted", 32'(halted), 32'd0);
        #3 rst_n = 1'b1;
        wait_idle(40, "arst");
        check("arst_pc_end", pc, 32'd5);

        // Randomized: random memory, random backpressure and redirects.
        for (int i = 0; i < 1024; i++)
            mem[i] = ($urandom % 12 == 0) ? c_HALT : $urandom;
        do_redirect(32'd0, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            redirect_valid = 1'b0;
            out_ready = ($urandom % 4) != 0;
            if ($urandom % 30 == 0) begin
                tgt = $urandom_range(0, 1005);
                redirect_valid = 1'b1;
                redirect_pc = tgt;
                load_expect(tgt);
            end
        end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle(1200, "rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
